// File: rtl/pulse_pkg.sv
// -----------------------------------------------------------------------------
// pulse_pkg
//   Shared definitions for the pulse_spacer block. Holds the FSM state
//   encoding, the smallest legal pulse spacing, and a helper that returns the
//   saturation value of the pending-event counter.
//   Optional feature macro used by the block: PULSE_SPACER_CLR_EN.
// -----------------------------------------------------------------------------
package pulse_pkg;

  // IDLE: nothing in flight. HOLD: a strobe was emitted and the gap is timing.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // A spacing of 1 would let strobes touch; the synchroniser needs a real gap.
  localparam int GAP_MIN = 2;

  // Largest value the pending counter may hold before events are dropped.
  function automatic int pend_max(input int cnt_w);
    return (2 ** cnt_w) - 1;
  endfunction

endpackage

// File: rtl/pulse_spacer_gapcnt.sv
// -----------------------------------------------------------------------------
// pulse_spacer_gapcnt
//   Loadable down-counter that times the gap between successive strobes.
//   Loading puts GAP-1 into the counter; it then counts down one per cycle and
//   rests at zero. o_expire is high while the count is zero, which in HOLD is
//   exactly GAP cycles after the emit decision that loaded it.
//   Optional feature macro of the enclosing block: PULSE_SPACER_CLR_EN
//   (no effect on this module).
// Ports
//   clka      in   clock
//   rst_n     in   asynchronous active-low reset
//   i_load    in   reload the counter with GAP-1
//   o_expire  out  count has reached zero
// -----------------------------------------------------------------------------
module pulse_spacer_gapcnt #(
  parameter int GAP = 8
) (
  input  logic clka,
  input  logic rst_n,
  input  logic i_load,
  output logic o_expire
);

  localparam int CW = $clog2(GAP);
  localparam logic [CW-1:0] LOAD_VAL = CW'(GAP - 1);

  logic [CW-1:0] r_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create ordering-dependent races.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/pulse_spacer.sv
// -----------------------------------------------------------------------------
// pulse_spacer
//   Front end for a fast-to-slow pulse synchroniser. Raw one-cycle requests,
//   possibly back-to-back, are counted and re-emitted as one-cycle strobes
//   whose rising edges are at least GAP clka cycles apart.
//   Optional feature macro: PULSE_SPACER_CLR_EN -- adds ovf_clr, which clears
//   the sticky overflow flag (a same-cycle drop wins). Without it, overflow
//   clears only on reset.
// Ports
//   clka       in   clock
//   rst_n      in   asynchronous active-low reset
//   pulse_in   in   request strobe, one event per high cycle
//   ovf_clr    in   clear overflow (PULSE_SPACER_CLR_EN only)
//   pulse_out  out  spaced strobe, registered, one cycle wide
//   pending    out  events accepted but not yet emitted (registered)
//   busy       out  FSM not idle or backlog non-empty
//   overflow   out  sticky: at least one event was dropped
// -----------------------------------------------------------------------------
module pulse_spacer
  import pulse_pkg::*;
#(
  parameter int GAP   = 8,
  parameter int CNT_W = 4
) (
  input  logic             clka,
  input  logic             rst_n,
  input  logic             pulse_in,
`ifdef PULSE_SPACER_CLR_EN
  input  logic             ovf_clr,
`endif
  output logic             pulse_out,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(pend_max(CNT_W));
  localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

  // Elaboration stops on an illegal spacing: the missing module is deliberate.
  if (GAP < GAP_MIN) begin : g_gap_too_small
    pulse_spacer_gap_below_minimum u_gap_check ();
  end

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_pulse_out;
  logic [CNT_W-1:0] r_pending;
  logic             r_overflow;

  logic w_expire;
  logic w_req;
  logic w_emit;
  logic w_from_backlog;
  logic w_accept;
  logic w_drop;

  pulse_spacer_gapcnt #(.GAP(GAP)) u_gapcnt (
    .clka     (clka),
    .rst_n    (rst_n),
    .i_load   (w_emit),
    .o_expire (w_expire)
  );

  assign w_req = (r_pending != '0) || pulse_in;

  // NOTE: every signal written here gets a default first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_emit      = 1'b1;
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Back-to-back emits stay in HOLD so the next edge lands exactly GAP on.
        if (w_expire) begin
          if (w_req) w_emit = 1'b1;
          else       w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The backlog is served first; a request arriving alongside is then counted.
  assign w_from_backlog = w_emit && (r_pending != '0);
  assign w_accept       = pulse_in && !(w_emit && !w_from_backlog);
  assign w_drop         = w_accept && !w_from_backlog && (r_pending == PEND_MAX);

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_pulse_out <= 1'b0;
      r_pending   <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pulse_out <= w_emit;

      case ({w_accept, w_from_backlog})
        2'b10:   if (!w_drop) r_pending <= r_pending + PEND_ONE;
        2'b01:   r_pending <= r_pending - PEND_ONE;
        default: r_pending <= r_pending;
      endcase

      if (w_drop) begin
        r_overflow <= 1'b1;
`ifdef PULSE_SPACER_CLR_EN
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
`endif
      end
    end
  end

  assign pulse_out = r_pulse_out;
  assign pending   = r_pending;
  assign overflow  = r_overflow;
  assign busy      = (r_state != ST_IDLE) || (r_pending != '0);

endmodule

// File: tb/tb_pulse_spacer.sv
// -----------------------------------------------------------------------------
// tb_pulse_spacer
//   Self-checking bench for pulse_spacer (GAP=8, CNT_W=4). The reference model
//   tracks the backlog as a plain count and the time since the last emit
//   decision; a strobe may be emitted whenever at least GAP cycles have passed.
//   Optional feature macro: PULSE_SPACER_CLR_EN (exercises ovf_clr).
// -----------------------------------------------------------------------------
module tb_pulse_spacer;

  localparam int GAP   = 8;
  localparam int CNT_W = 4;
  localparam int PMAX  = (2 ** CNT_W) - 1;
`ifdef PULSE_SPACER_CLR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic             clka = 1'b0;
  logic             rst_n;
  logic             pulse_in;
`ifdef PULSE_SPACER_CLR_EN
  logic             ovf_clr;
`endif
  logic             pulse_out;
  logic [CNT_W-1:0] pending;
  logic             busy;
  logic             overflow;

  pulse_spacer #(.GAP(GAP), .CNT_W(CNT_W)) dut (
    .clka      (clka),
    .rst_n     (rst_n),
    .pulse_in  (pulse_in),
`ifdef PULSE_SPACER_CLR_EN
    .ovf_clr   (ovf_clr),
`endif
    .pulse_out (pulse_out),
    .pending   (pending),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clka = ~clka;

  int n_checks = 0;
  int n_fail   = 0;
  int pout_count = 0;
  int pend_peak  = 0;

  // Reference model state
  int m_pending;
  int m_since;   // cycles since the last emit decision
  bit m_ovf;
  bit m_pout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pending = 0;
    m_since   = GAP + 1;
    m_ovf     = 1'b0;
    m_pout    = 1'b0;
  endtask

  // Called #1 after a rising edge: drives one cycle, advances the model, and
  // checks the outputs #1 after the next rising edge.
  task automatic step(input bit p, input bit clr);
    bit emit;
    bit consumed;
    bit drop;
    pulse_in = p;
`ifdef PULSE_SPACER_CLR_EN
    ovf_clr = clr;
`endif
    emit     = (m_since >= GAP) && ((m_pending > 0) || p);
    consumed = 1'b0;
    drop     = 1'b0;
    if (emit) begin
      if (m_pending > 0) m_pending--;
      else               consumed = 1'b1;
    end
    if (p && !consumed) begin
      if (m_pending < PMAX) m_pending++;
      else                  drop = 1'b1;
    end
    if (drop)                m_ovf = 1'b1;
    else if (CLR_EN && clr)  m_ovf = 1'b0;
    if (emit)              m_since = 1;
    else if (m_since <= GAP) m_since++;
    m_pout = emit;

    @(posedge clka);
    #1;
    if (pulse_out === 1'b1) pout_count++;
    if (int'(pending) > pend_peak) pend_peak = int'(pending);
    check("pulse_out", {31'd0, pulse_out}, {31'd0, m_pout});
    check("pending",   {28'd0, pending},   32'(m_pending));
    check("overflow",  {31'd0, overflow},  {31'd0, m_ovf});
    check("busy",      {31'd0, busy},      {31'd0, (m_pending != 0) || (m_since <= GAP)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    int c0;
    int density;

    rst_n    = 1'b0;
    pulse_in = 1'b0;
`ifdef PULSE_SPACER_CLR_EN
    ovf_clr  = 1'b0;
`endif
    model_reset();
    repeat (3) @(posedge clka);
    #1;
    check("rst_pulse_out", {31'd0, pulse_out}, 32'd0);
    check("rst_pending",   {28'd0, pending},   32'd0);
    check("rst_overflow",  {31'd0, overflow},  32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    rst_n = 1'b1;

    // Single request: one strobe the next cycle, busy for GAP cycles.
    idle(8);
    c0 = pout_count;
    step(1'b1, 1'b0);
    check("t1_latency", {31'd0, pulse_out}, 32'd1);
    idle(12);
    check("t1_count", 32'(pout_count - c0), 32'd1);

    // Three back-to-back requests: strobes GAP apart.
    c0 = pout_count;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("t2_pending", {28'd0, pending}, 32'd2);
    idle(30);
    check("t2_count", 32'(pout_count - c0), 32'd3);

    // Twenty back-to-back requests: saturate, drop two, emit eighteen.
    c0 = pout_count;
    pend_peak = 0;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
    check("t3_peak",     32'(pend_peak), 32'(PMAX));
    check("t3_overflow", {31'd0, overflow}, 32'd1);
    idle(18 * GAP + 10);
    check("t3_count", 32'(pout_count - c0), 32'd18);
    check("t3_sticky", {31'd0, overflow}, 32'd1);

`ifdef PULSE_SPACER_CLR_EN
    // Clear alone takes effect next cycle; clear coincident with a drop loses.
    step(1'b0, 1'b1);
    check("t6_clr", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 19; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("t6_clr_vs_drop", {31'd0, overflow}, 32'd1);
    idle(18 * GAP + 10);
`endif

    // Asynchronous reset mid-HOLD with a backlog of five.
    idle(4);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("t4_backlog", {28'd0, pending}, 32'd5);
    #1;
    rst_n = 1'b0;
    #1;
    check("t4_pulse_out", {31'd0, pulse_out}, 32'd0);
    check("t4_pending",   {28'd0, pending},   32'd0);
    check("t4_overflow",  {31'd0, overflow},  32'd0);
    check("t4_busy",      {31'd0, busy},      32'd0);
    model_reset();
    @(posedge clka);
    #1;
    rst_n = 1'b1;
    c0 = pout_count;
    idle(3 * GAP);
    check("t4_no_output", 32'(pout_count - c0), 32'd0);

    // Random traffic at several densities against the model.
    for (int seg = 0; seg < 4; seg++) begin
      density = (seg == 0) ? 10 : (seg == 1) ? 40 : (seg == 2) ? 90 : 60;
      for (int i = 0; i < 150; i++)
        step($urandom_range(0, 99) < density, CLR_EN && ($urandom_range(0, 49) == 0));
    end
    idle(PMAX * GAP + 10);
    check("drain_pending", {28'd0, pending}, 32'd0);
    check("drain_busy",    {31'd0, busy},    32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
